vip_frame_ctrl: RTL and testbench

Frame-synchronous mode scheduler for the video image processor chain (RGB565 -> YCbCr -> gray median filter). Accepts mode-change requests from a key or UART config source over a valid/ready handshake. Applies each change only at a frame start, so no frame is ever processed half in one mode and half in another. Drives the output mux select and an output mask that blanks frames still corrupted by filter line-buffer history after a switch.

---
 rtl/vip_frame_ctrl.sv | 151 +++++++++++++++
 tb/tb_vip_frame_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/vip_frame_ctrl.sv
// Frame-synchronous mode scheduler for the video processing chain: applies mode changes only at frame start.
// Optional geometry statistics are built when VIP_FRAME_STATS_EN is defined.
//
// state    | meaning
// WAIT_SOF | after reset, waiting for the first clean frame start
// FRAME    | inside an active frame (vsync high)
// VBLANK   | between frames, waiting for the next frame start
module vip_frame_ctrl #(
  parameter int DEFAULT_MODE = 2,
  parameter int DROP_FRAMES  = 1,
  parameter int FRAME_CNT_W  = 16,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   per_frame_vsync,
  input  logic                   per_frame_href,
  input  logic                   per_frame_clken,
  input  logic [1:0]             cfg_mode,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  output logic [1:0]             mode_sel,
  output logic                   mode_apply,
  output logic                   frame_mask,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   err_cfg,
  output logic [10:0]            line_cnt,
  output logic                   geom_err
);

  typedef enum logic [1:0] {WAIT_SOF, FRAME, VBLANK} state_t;

  state_t     state, state_nxt;
  logic       vs_d;
  logic       sof, eof;
  logic       pend_valid;
  logic [1:0] pend_mode;
  logic [3:0] drop_cnt, drop_nxt;
  logic       apply_now, apply_change, frame_end;

  // vs_d resets high so a frame already running at reset release is not taken as a start
  assign sof = per_frame_vsync & ~vs_d;
  assign eof = ~per_frame_vsync & vs_d;
  assign cfg_ready = ~pend_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_SOF;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_SOF: if (sof) state_nxt = FRAME;
      FRAME:    if (eof) state_nxt = VBLANK;
      VBLANK:   if (sof) state_nxt = FRAME;
      default:  state_nxt = WAIT_SOF;
    endcase
  end

  always_comb begin
    apply_now = 1'b0;
    frame_end = 1'b0;
    case (state)
      WAIT_SOF, VBLANK: apply_now = sof & pend_valid;
      FRAME:            frame_end = eof;
      default:          ;
    endcase
  end

  assign apply_change = apply_now && (pend_mode != mode_sel);

  always_comb begin
    drop_nxt = drop_cnt;
    if (apply_change)                      drop_nxt = 4'(DROP_FRAMES);
    else if (frame_end && drop_cnt != 4'd0) drop_nxt = drop_cnt - 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_d       <= 1'b1;
      mode_sel   <= 2'(DEFAULT_MODE);
      pend_valid <= 1'b0;
      pend_mode  <= 2'd0;
      mode_apply <= 1'b0;
      frame_mask <= 1'b0;
      err_cfg    <= 1'b0;
      frame_cnt  <= '0;
      drop_cnt   <= 4'd0;
    end else begin
      vs_d       <= per_frame_vsync;
      mode_apply <= apply_change;
      drop_cnt   <= drop_nxt;
      frame_mask <= (drop_nxt != 4'd0);
      // reserved mode 3 completes the handshake but never enters the buffer
      if (apply_now)
        pend_valid <= 1'b0;
      else if (cfg_valid && !pend_valid && cfg_mode != 2'd3) begin
        pend_valid <= 1'b1;
        pend_mode  <= cfg_mode;
      end
      if (cfg_valid && !pend_valid && cfg_mode == 2'd3)
        err_cfg <= 1'b1;
      if (apply_change)
        mode_sel <= pend_mode;
      if (frame_end)
        frame_cnt <= frame_cnt + 1'b1;
    end
  end

`ifdef VIP_FRAME_STATS_EN
  logic        href_d;
  logic        href_fall;
  logic [15:0] pix_cnt;
  logic [10:0] line_cnt_r;
  logic        geom_err_r;

  assign href_fall = ~per_frame_href & href_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      href_d     <= 1'b0;
      pix_cnt    <= 16'd0;
      line_cnt_r <= 11'd0;
      geom_err_r <= 1'b0;
    end else begin
      href_d     <= per_frame_href;
      geom_err_r <= (href_fall && pix_cnt != 16'(H_ACTIVE)) ||
                    (frame_end && line_cnt_r != 11'(V_ACTIVE));
      if (href_fall)
        pix_cnt <= 16'd0;
      else if (per_frame_clken && per_frame_href)
        pix_cnt <= pix_cnt + 16'd1;
      if (sof)
        line_cnt_r <= 11'd0;
      else if (href_fall)
        line_cnt_r <= line_cnt_r + 11'd1;
    end
  end

  assign line_cnt = line_cnt_r;
  assign geom_err = geom_err_r;
`else
  logic unused_stats;
  assign unused_stats = ^{per_frame_href, per_frame_clken, 32'(H_ACTIVE), 32'(V_ACTIVE)};
  assign line_cnt = 11'd0;
  assign geom_err = 1'b0;
`endif

endmodule

// File: tb/tb_vip_frame_ctrl.sv
// Scoreboarded bench for vip_frame_ctrl: directed frames, config requests and reset cases on two instances.
module tb_vip_frame_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1, rst3 = 1'b1;
  logic vsync = 1'b1, href = 1'b0, clken = 1'b0;
  logic [1:0] cfg_mode = 2'd0;
  logic cfg_valid = 1'b0, cfg_valid3 = 1'b0;

  logic        cfg_ready, mode_apply, frame_mask, err_cfg, geom_err;
  logic [1:0]  mode_sel;
  logic [15:0] frame_cnt;
  logic [10:0] line_cnt;

  logic        cfg_ready3, mode_apply3, frame_mask3, err_cfg3, geom_err3;
  logic [1:0]  mode_sel3;
  logic [15:0] frame_cnt3;
  logic [10:0] line_cnt3;

  always #5 clk = ~clk;

  vip_frame_ctrl #(.DEFAULT_MODE(2), .DROP_FRAMES(1), .FRAME_CNT_W(16), .H_ACTIVE(8), .V_ACTIVE(4)) dut (
    .clk(clk), .rst(rst), .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
    .cfg_mode(cfg_mode), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .mode_sel(mode_sel),
    .mode_apply(mode_apply), .frame_mask(frame_mask), .frame_cnt(frame_cnt), .err_cfg(err_cfg),
    .line_cnt(line_cnt), .geom_err(geom_err));

  vip_frame_ctrl #(.DEFAULT_MODE(2), .DROP_FRAMES(3), .FRAME_CNT_W(16), .H_ACTIVE(8), .V_ACTIVE(4)) dut3 (
    .clk(clk), .rst(rst3), .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
    .cfg_mode(cfg_mode), .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3), .mode_sel(mode_sel3),
    .mode_apply(mode_apply3), .frame_mask(frame_mask3), .frame_cnt(frame_cnt3), .err_cfg(err_cfg3),
    .line_cnt(line_cnt3), .geom_err(geom_err3));

  int checks = 0, failures = 0;
  int exp_fc = 0;
  int apply_q[$];
  int geom_q[$];

  int s_apply, s_mode, s_mask, s_ready, s_apply3, s_mode3, s_mask3;
  int e_mask, e_mask3, e_lc, a_mask, a_mask3;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: every mode_apply / geom_err pulse must match a queued expectation
  logic prev_apply = 1'b0;
  always begin
    @(posedge clk);
    #1;
    if (!rst) begin
      if (mode_apply) begin
        chk("apply_single_cycle", int'(prev_apply), 0);
        if (apply_q.size() == 0) chk("unexpected_mode_apply", 1, 0);
        else chk("mode_sel_at_apply", int'(mode_sel), apply_q.pop_front());
      end
      if (geom_err) begin
        if (geom_q.size() == 0) chk("unexpected_geom_err", 1, 0);
        else chk("line_cnt_at_geom_err", int'(line_cnt), geom_q.pop_front());
      end
    end
    prev_apply = mode_apply;
  end

  // One frame: nlines lines of 8 pixels (line index short_line has 7); optional request at sof
  task automatic send_frame(input int nlines, input int short_line, input int req_mode);
    @(negedge clk);
    vsync = 1'b1;
    if (req_mode >= 0) begin
      cfg_mode  = 2'(req_mode);
      cfg_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    s_apply = mode_apply;  s_mode = mode_sel;  s_mask = frame_mask;  s_ready = cfg_ready;
    s_apply3 = mode_apply3; s_mode3 = mode_sel3; s_mask3 = frame_mask3;
    @(negedge clk);
    if (req_mode >= 0) cfg_valid = 1'b0;
    for (int l = 0; l < nlines; l++) begin
      for (int p = 0; p < ((l == short_line) ? 7 : 8); p++) begin
        href = 1'b1; clken = 1'b1;
        @(negedge clk);
      end
      href = 1'b0; clken = 1'b0;
      repeat (2) @(negedge clk);
    end
    e_mask = frame_mask; e_mask3 = frame_mask3; e_lc = line_cnt;
    vsync = 1'b0;
    @(posedge clk);
    #1;
    a_mask = frame_mask; a_mask3 = frame_mask3;
    exp_fc++;
    chk("frame_cnt_after_eof", int'(frame_cnt), exp_fc);
    repeat (3) @(negedge clk);
  endtask

  task automatic req(input int m, input bit on3);
    @(negedge clk);
    cfg_mode = 2'(m);
    if (on3) cfg_valid3 = 1'b1; else cfg_valid = 1'b1;
    @(posedge clk);
    #1;
    if (m != 3) chk("cfg_ready_after_accept", on3 ? int'(cfg_ready3) : int'(cfg_ready), 0);
    else begin
      chk("err_cfg_set", int'(err_cfg), 1);
      chk("cfg_ready_after_reserved", int'(cfg_ready), 1);
    end
    @(negedge clk);
    cfg_valid = 1'b0; cfg_valid3 = 1'b0;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset values, release mid-frame, partial frame not counted
    repeat (2) @(negedge clk);
    chk("rst_mode_sel", int'(mode_sel), 2);
    chk("rst_cfg_ready", int'(cfg_ready), 1);
    chk("rst_mode_apply", int'(mode_apply), 0);
    chk("rst_frame_mask", int'(frame_mask), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    chk("rst_err_cfg", int'(err_cfg), 0);
    chk("rst_line_cnt", int'(line_cnt), 0);
    chk("rst_geom_err", int'(geom_err), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    chk("partial_frame_not_counted", int'(frame_cnt), 0);
    send_frame(4, -1, -1);
    send_frame(4, -1, -1);
    chk("t1_frame_cnt", int'(frame_cnt), 2);
    chk("t1_mode_sel", int'(mode_sel), 2);
    chk("t1_mask", e_mask, 0);

    // 2: request during a frame, applied at next sof with a one-frame mask
    fork
      send_frame(4, -1, -1);
      begin repeat (5) @(negedge clk); req(1, 1'b0); end
    join
    chk("t2_mode_not_yet", int'(mode_sel), 2);
    chk("t2_no_mask_yet", a_mask, 0);
    apply_q.push_back(1);
    send_frame(4, -1, -1);
    chk("t2_start_mode", s_mode, 1);
    chk("t2_start_apply", s_apply, 1);
    chk("t2_start_mask", s_mask, 1);
    chk("t2_start_ready", s_ready, 1);
    chk("t2_mask_before_eof", e_mask, 1);
    chk("t2_mask_after_eof", a_mask, 0);

    // 3: request coincident with sof waits one frame
    send_frame(4, -1, 0);
    chk("t3_start_mask", s_mask, 0);
    chk("t3_start_mode", s_mode, 1);
    chk("t3_start_apply", s_apply, 0);
    chk("t3_start_ready", s_ready, 0);
    apply_q.push_back(0);
    send_frame(4, -1, -1);
    chk("t3_next_mode", s_mode, 0);
    chk("t3_next_apply", s_apply, 1);

    // 4: reserved mode and same-mode request
    req(3, 1'b0);
    send_frame(4, -1, -1);
    chk("t4_reserved_mode", s_mode, 0);
    chk("t4_reserved_apply", s_apply, 0);
    req(0, 1'b0);
    send_frame(4, -1, -1);
    chk("t4_same_apply", s_apply, 0);
    chk("t4_same_mask_start", s_mask, 0);
    chk("t4_same_mask_mid", e_mask, 0);
    chk("t4_same_ready", s_ready, 1);
    chk("t4_err_sticky", int'(err_cfg), 1);

    // 5: DROP_FRAMES = 3 instance, then reset in the second masked frame
    @(negedge clk);
    rst3 = 1'b0;
    repeat (2) @(negedge clk);
    req(1, 1'b1);
    send_frame(4, -1, -1);
    chk("t5_apply3", s_apply3, 1);
    chk("t5_mode3", s_mode3, 1);
    chk("t5_mask3_f1_start", s_mask3, 1);
    chk("t5_mask3_f1_after", a_mask3, 1);
    send_frame(4, -1, -1);
    chk("t5_mask3_f2_after", a_mask3, 1);
    send_frame(4, -1, -1);
    chk("t5_mask3_f3_mid", e_mask3, 1);
    chk("t5_mask3_f3_after", a_mask3, 0);
    req(0, 1'b1);
    send_frame(4, -1, -1);
    chk("t5_mask3_r_start", s_mask3, 1);
    fork
      send_frame(4, -1, -1);
      begin
        repeat (6) @(negedge clk);
        chk("t5_mask3_before_rst", int'(frame_mask3), 1);
        rst3 = 1'b1;
        #1;
        chk("t5_rst_mode_sel", int'(mode_sel3), 2);
        chk("t5_rst_cfg_ready", int'(cfg_ready3), 1);
        chk("t5_rst_mode_apply", int'(mode_apply3), 0);
        chk("t5_rst_frame_mask", int'(frame_mask3), 0);
        chk("t5_rst_frame_cnt", int'(frame_cnt3), 0);
        chk("t5_rst_err_cfg", int'(err_cfg3), 0);
      end
    join

    // 6: geometry statistics
`ifdef VIP_FRAME_STATS_EN
    geom_q.push_back(2);
    send_frame(4, 1, -1);
    chk("t6_line_cnt_at_eof", e_lc, 4);
    geom_q.push_back(5);
    send_frame(5, -1, -1);
    chk("t6_line_cnt_5", e_lc, 5);
`else
    send_frame(4, 1, -1);
    chk("t6_line_cnt_tied", e_lc, 0);
`endif

    repeat (4) @(negedge clk);
    chk("apply_q_drained", apply_q.size(), 0);
    chk("geom_q_drained", geom_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
